// File: rtl/icap_boot_pkg.sv
// Shared types, fixed ICAPE2 command words and helpers for the reboot sequencer.
package icap_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLDOFF = 3'd1,
        ST_SETUP   = 3'd2,
        ST_WRITE   = 3'd3,
        ST_TAIL    = 3'd4,
        ST_DONE    = 3'd5
    } boot_state_t;

    // Number of words pushed through ICAPE2 in one reboot burst.
    localparam int unsigned WORD_COUNT = 8;

    // Fixed words of the IPROG sequence; word 4 is the WBSTAR address.
    localparam logic [31:0] CMD_DUMMY     = 32'hFFFF_FFFF;
    localparam logic [31:0] CMD_SYNC      = 32'hAA99_5566;
    localparam logic [31:0] CMD_NOOP      = 32'h2000_0000;
    localparam logic [31:0] CMD_WR_WBSTAR = 32'h3002_0001;
    localparam logic [31:0] CMD_WR_CMD    = 32'h3000_8001;
    localparam logic [31:0] CMD_IPROG     = 32'h0000_000F;
    localparam logic [31:0] CMD_NOOP_TAIL = 32'h2000_0000;

    // ICAPE2 expects every byte with its bit order mirrored.
    function automatic logic [31:0] bit_swap_bytes(input logic [31:0] word);
        logic [31:0] swapped;
        swapped = '0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) begin
                swapped[8*k + 7 - i] = word[8*k + i];
            end
        end
        return swapped;
    endfunction

    // Unswapped command word at a given burst position.
    function automatic logic [31:0] boot_word(input logic [2:0] idx, input logic [31:0] addr);
        logic [31:0] word;
        case (idx)
            3'd0:    word = CMD_DUMMY;
            3'd1:    word = CMD_SYNC;
            3'd2:    word = CMD_NOOP;
            3'd3:    word = CMD_WR_WBSTAR;
            3'd4:    word = addr;
            3'd5:    word = CMD_WR_CMD;
            3'd6:    word = CMD_IPROG;
            default: word = CMD_NOOP_TAIL;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/icap_boot_seq.sv
// Reboot sequencer: arbitrates a user/golden request, waits a holdoff period,
// then writes the 8-word IPROG sequence into ICAPE2 and parks in DONE.
module icap_boot_seq
    import icap_boot_pkg::*;
#(
    parameter logic [31:0] USER_ADDR   = 32'h0200_0000,
    parameter logic [31:0] GOLDEN_ADDR = 32'h0000_0000,
    parameter logic [15:0] HOLDOFF     = 16'd1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_user,
    input  logic        req_golden,
    input  logic        cancel,
    output logic        icap_csib,
    output logic        icap_rdwrb,
    output logic [31:0] icap_data,
    output logic        busy,
    output logic        granted_golden,
    output boot_state_t state_dbg
);

    // Handshake: req_user/req_golden are levels sampled only in IDLE; a request
    // is consumed on the rising edge that moves IDLE->HOLDOFF, nothing is queued.

    localparam logic [2:0] LAST_IDX = 3'(WORD_COUNT - 1);

    boot_state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic        golden_q, golden_d;
    logic [31:0] sel_addr;

    // State, holdoff counter, word index and latched selection registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            golden_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            golden_q <= golden_d;
        end
    end

    // Next-state logic; golden wins a tie, cancel beats holdoff expiry.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        golden_d = golden_q;
        case (state_q)
            ST_IDLE: begin
                if (req_golden || req_user) begin
                    golden_d = req_golden;
                    cnt_d    = HOLDOFF;
                    state_d  = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (cancel) begin
                    golden_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end else if (cnt_q == 16'd0) begin
                    state_d = ST_SETUP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_SETUP: begin
                idx_d   = '0;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_TAIL;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_TAIL: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sel_addr = golden_q ? GOLDEN_ADDR : USER_ADDR;

    // ICAP pins decoded from the registered state; rdwrb drops one cycle
    // before chip select and rises only after it, so it never moves under csib=0.
    always_comb begin
        icap_csib  = 1'b1;
        icap_rdwrb = 1'b1;
        icap_data  = '0;
        case (state_q)
            ST_SETUP: icap_rdwrb = 1'b0;
            ST_WRITE: begin
                icap_csib  = 1'b0;
                icap_rdwrb = 1'b0;
                icap_data  = bit_swap_bytes(boot_word(idx_q, sel_addr));
            end
            ST_TAIL:  icap_rdwrb = 1'b0;
            default: begin
                icap_csib  = 1'b1;
                icap_rdwrb = 1'b1;
            end
        endcase
    end

    assign busy           = (state_q != ST_IDLE);
    assign granted_golden = golden_q;
    assign state_dbg      = state_q;

endmodule
